lsu_mem_stage: RTL
==================

# lsu_mem_stage

Memory-stage load/store unit of the rv32i pipeline, sitting directly upstream of the byte-addressed data memory. It accepts one load or store per request from the MEM stage and drives the memory's address, write-data and write-enable inputs. Loads are formatted (byte, half or word, sign- or zero-extended) from the registered memory read data. Byte and half stores are done as read-modify-write, because the memory always writes 4 bytes. The pipeline is stalled until the access completes.

## Interface
- DPW, 32 (from rv32i_pkg): data and address width.
- clk  in  1  clock; all state on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage has a memory instruction; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- req_addr  in  DPW  byte address (aluresultM).
- req_wdata  in  DPW  store data (Rd2M).
- req_ready  out  1  block is IDLE and can accept a request.
- stall  out  1  freeze the pipeline before MEM.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_err  out  1  valid with resp_valid; illegal funct3.
- resp_rdata  out  DPW  formatted load data; holds until the next load completes.
- dc_addr  out  DPW  memory address.
- dc_wd  out  DPW  memory write data.
- dc_we  out  1  memory write enable.
- dc_rd  in  DPW  memory read data; registered inside the memory, updated on each edge where dc_we=0.

The memory's backdoor load port is not driven by this block.

## Operation
- Byte order is little-endian: dc_wd/dc_rd[7:0] is the byte at dc_addr, [15:8] at dc_addr+1, and so on. No alignment restriction; the memory is byte-addressed.
- Accept: in IDLE with req_valid=1, latch addr, wdata, funct3 and we into a_*, then classify the request:
  - illegal: funct3 in {011, 110, 111}, or a store with funct3[2]=1.
  - SW.
  - SB/SH.
  - load.
- FSM states are IDLE, READ, LATCH, WRITE, RESP.
  - SW: IDLE -> WRITE -> RESP.
  - Load: IDLE -> READ -> LATCH -> RESP.
  - SB/SH: IDLE -> READ -> LATCH -> WRITE -> RESP.
  - Illegal: IDLE -> RESP with resp_err=1; no memory write.
  - RESP -> IDLE always.
- READ: dc_addr=a_addr, dc_we=0. The memory captures the word at this edge.
- LATCH: dc_rd is valid. Capture dc_rd into rbuf. For loads, also capture the formatted value into resp_rdata:
  - B: sign-extend [7:0].
  - BU: zero-extend [7:0].
  - H: sign-extend [15:0].
  - HU: zero-extend [15:0].
  - W: full 32 bits.
- WRITE: dc_we=1, dc_addr=a_addr, and dc_wd is:
  - SW: a_wdata.
  - SB: {rbuf[31:8], a_wdata[7:0]}.
  - SH: {rbuf[31:16], a_wdata[15:0]}.
- RESP: resp_valid=1; resp_err=1 only for illegal requests.
- Outside WRITE: dc_we=0 and dc_wd=0. Outside IDLE, dc_addr=a_addr; in IDLE it holds its last value.
- req_ready = (state==IDLE).
- stall = (state==IDLE && req_valid) || state in {READ, LATCH, WRITE}. stall is low in RESP, so the pipeline advances on the RESP edge and captures resp_rdata.

## Timing
- Counting the accept edge as edge 0, resp_valid is high in the cycle after:
  - edge 1 for SW and illegal requests;
  - edge 2 for loads;
  - edge 3 for SB/SH.
- dc_we is high for exactly one cycle per store and never for loads or illegal requests.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after RESP. There is no overlap.
- Reset (arst_n=0, asynchronous) sets:
  - state=IDLE;
  - dc_we=0, dc_wd=0, dc_addr=0;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - rbuf=0 and all a_*=0.
- Reset mid-operation abandons the request. Memory changes only at the edge ending WRITE, so an interrupted RMW leaves memory untouched. After release, the first edge with req_valid=1 is an accept.
- req_valid is sampled only in IDLE. Changes to req_* outside IDLE are ignored because latched copies are used.

## Test plan
- SW addr 0x10, data 0xDEADBEEF -> dc_we high only in the cycle after accept, with dc_addr=0x10 and dc_wd=0xDEADBEEF. resp_valid in the next cycle. stall high for 2 cycles.
- After that store, loads at 0x10 return:
  - LB 0xFFFFFFEF;
  - LBU 0x000000EF;
  - LH 0xFFFFBEEF;
  - LHU 0x0000BEEF;
  - LW 0xDEADBEEF.
  Each load raises resp_valid 3 cycles after accept, and dc_we stays 0.
- SB addr 0x11, data 0x12345655, then LW 0x10 -> 0xDEAD55EF. Then SH addr 0x12, data 0xAAAA1234, then LW 0x10 -> 0x123455EF. dc_we is high exactly once per store, in the 4th cycle.
- Illegal requests: load funct3=011, and store funct3=100 -> resp_valid=resp_err=1 one cycle after accept; dc_we never asserted; resp_rdata unchanged.
- Assert arst_n=0 during LATCH of SB addr 0x10 -> all outputs zero immediately and LW 0x10 still returns the prior value. Release reset, then issue a request -> accepted on the first edge.
- Six back-to-back mixed requests with req_valid held high -> each accepted in the IDLE cycle following the previous RESP. Responses arrive in order with no dropped or duplicated resp_valid.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
//
// Bundles every signal between the load/store unit and its two neighbours:
// the MEM pipeline stage (request/response) and the byte-addressed data memory
// (dc_*). The clock and reset are not part of the bundle.
//
// Handshake: a request is taken on a rising edge where req_valid=1 and
// req_ready=1. The requester holds req_* stable while stall=1. Completion is
// a single-cycle resp_valid pulse (with resp_err); resp_rdata holds the most
// recent load result until the next load completes.
//
// Modports
//   slave  : the load/store unit (consumes req_*, dc_rd; drives the rest).
//   master : the surrounding environment, i.e. the MEM stage together with
//            the data memory (drives req_* and dc_rd).
// -----------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int DPW = 32
) ();
    // MEM stage request
    logic           req_valid;
    logic           req_we;
    logic [2:0]     req_funct3;
    logic [DPW-1:0] req_addr;
    logic [DPW-1:0] req_wdata;

    // Flow control and response back to the pipeline
    logic           req_ready;
    logic           stall;
    logic           resp_valid;
    logic           resp_err;
    logic [DPW-1:0] resp_rdata;

    // Data memory port
    logic [DPW-1:0] dc_addr;
    logic [DPW-1:0] dc_wd;
    logic           dc_we;
    logic [DPW-1:0] dc_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_err, resp_rdata,
        output dc_addr, dc_wd, dc_we,
        input  dc_rd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_err, resp_rdata,
        input  dc_addr, dc_wd, dc_we,
        output dc_rd
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//
// Memory-stage load/store unit of the rv32i pipeline. Takes one load or store
// at a time from the MEM stage, drives the byte-addressed data memory and
// stalls the pipeline until the access completes.
//
//   * Loads: read the word at the byte address, then format it (B/BU/H/HU/W,
//     sign or zero extended) into resp_rdata.
//   * SW: single write cycle.
//   * SB/SH: read-modify-write, since the memory always writes 4 bytes.
//   * Illegal funct3 (011, 110, 111, or any store with funct3[2]=1) completes
//     immediately with resp_err=1 and never touches memory.
//
// Data is little-endian: bits [7:0] of dc_wd/dc_rd are the byte at dc_addr.
// The memory registers its read data on every edge where dc_we=0, so the word
// read in READ is visible on dc_rd during LATCH.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   arst_n     asynchronous active-low reset
//   bus        lsu_mem_stage_if.slave: req_*, req_ready, stall, resp_*, dc_*
//   dbg_state  current FSM state (IDLE=0, READ=1, LATCH=2, WRITE=3, RESP=4)
// -----------------------------------------------------------------------------
module lsu_mem_stage (
    input  logic                  clk,
    input  logic                  arst_n,
    lsu_mem_stage_if.slave        bus,
    output logic [2:0]            dbg_state
);
    // Data/address width of the rv32i datapath.
    localparam int DPW = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_e state_q;
    state_e state_d;

    // Latched copy of the accepted request; req_* may change once accepted.
    logic [DPW-1:0] a_addr;
    logic [DPW-1:0] a_wdata;
    logic [2:0]     a_funct3;
    logic           a_we;
    logic           a_err;

    logic [DPW-1:0] rbuf;       // raw word read for a load or an RMW
    logic [DPW-1:0] rdata_q;    // formatted load result, held between loads

    logic           req_illegal;
    logic           req_is_sw;
    logic           accept;

    logic [DPW-1:0] load_fmt;
    logic [DPW-1:0] store_merge;

    // FSM outputs
    logic           fsm_ready;
    logic           fsm_stall;
    logic           fsm_we;
    logic           fsm_resp;

    // -------------------------------------------------------------------------
    // Request classification (combinational, on the live request in IDLE)
    // -------------------------------------------------------------------------
    assign req_illegal = (bus.req_funct3 == 3'b011) ||
                         (bus.req_funct3 == 3'b110) ||
                         (bus.req_funct3 == 3'b111) ||
                         (bus.req_we && bus.req_funct3[2]);

    assign req_is_sw   = bus.req_we && (bus.req_funct3 == F3_W);

    assign accept      = (state_q == S_IDLE) && bus.req_valid;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        fsm_ready = 1'b0;
        fsm_stall = 1'b0;
        fsm_we    = 1'b0;
        fsm_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                fsm_ready = 1'b1;
                // Stall already in the accept cycle so the stage before MEM
                // does not advance underneath the request.
                fsm_stall = bus.req_valid;
                if (bus.req_valid) begin
                    if (req_illegal) begin
                        state_d = S_RESP;
                    end else if (req_is_sw) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                fsm_stall = 1'b1;
                state_d   = S_LATCH;
            end

            S_LATCH: begin
                fsm_stall = 1'b1;
                // Only SB/SH reach LATCH with a_we set.
                state_d   = a_we ? S_WRITE : S_RESP;
            end

            S_WRITE: begin
                fsm_stall = 1'b1;
                fsm_we    = 1'b1;
                state_d   = S_RESP;
            end

            S_RESP: begin
                // stall drops here so the pipeline captures resp_rdata on
                // the edge that returns us to IDLE.
                fsm_resp = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_addr   <= '0;
            a_wdata  <= '0;
            a_funct3 <= '0;
            a_we     <= 1'b0;
            a_err    <= 1'b0;
        end else if (accept) begin
            a_addr   <= bus.req_addr;
            a_wdata  <= bus.req_wdata;
            a_funct3 <= bus.req_funct3;
            a_we     <= bus.req_we;
            a_err    <= req_illegal;
        end
    end

    // -------------------------------------------------------------------------
    // Load formatting of the word currently on dc_rd
    // -------------------------------------------------------------------------
    always_comb begin
        load_fmt = bus.dc_rd;
        case (a_funct3)
            F3_B:    load_fmt = {{24{bus.dc_rd[7]}},  bus.dc_rd[7:0]};
            F3_BU:   load_fmt = {24'h000000,          bus.dc_rd[7:0]};
            F3_H:    load_fmt = {{16{bus.dc_rd[15]}}, bus.dc_rd[15:0]};
            F3_HU:   load_fmt = {16'h0000,            bus.dc_rd[15:0]};
            default: load_fmt = bus.dc_rd;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read capture: rbuf for RMW, rdata_q for loads. rdata_q is left alone by
    // stores and illegal requests so it keeps the last load result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rbuf    <= '0;
            rdata_q <= '0;
        end else if (state_q == S_LATCH) begin
            rbuf <= bus.dc_rd;
            if (!a_we) begin
                rdata_q <= load_fmt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write data: SW writes the store data as-is; SB/SH merge the new low
    // byte/half into the word read at the same byte address.
    // -------------------------------------------------------------------------
    always_comb begin
        case (a_funct3[1:0])
            2'b00:   store_merge = {rbuf[31:8],  a_wdata[7:0]};
            2'b01:   store_merge = {rbuf[31:16], a_wdata[15:0]};
            default: store_merge = a_wdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // a_addr only changes on the accept edge, after which the FSM is out of
    // IDLE, so it also gives the "hold last address while IDLE" behaviour.
    assign bus.dc_addr    = a_addr;
    assign bus.dc_we      = fsm_we;
    assign bus.dc_wd      = fsm_we ? store_merge : '0;

    assign bus.req_ready  = fsm_ready;
    assign bus.stall      = fsm_stall;
    assign bus.resp_valid = fsm_resp;
    assign bus.resp_err   = fsm_resp && a_err;
    assign bus.resp_rdata = rdata_q;

    assign dbg_state      = state_q;

endmodule
